// File: rtl/priority_arbiter.sv
// N-way priority arbiter with a one-hot registered grant.
// Fixed priority (highest index wins) or round-robin from a rotating pointer, with optional grant hold.
module priority_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mode,
    input  logic             hold,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [N-1:0]     gnt_q,       gnt_d;
    logic [IDX_W-1:0] gnt_idx_q,   gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0] ptr_q,       ptr_d;

    int  fix_w;
    int  rr_w;
    int  rr_best;
    int  rr_dist;
    int  ptr_i;
    int  win;
    logic hold_keep;

    // Fixed-priority winner: the ascending scan leaves the highest set index.
    always_comb begin
        fix_w = 0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) fix_w = i;
        end
    end

    // Round-robin winner: the set bit at the smallest circular distance from ptr.
    always_comb begin
        ptr_i   = int'(ptr_q);
        rr_w    = 0;
        rr_best = N;
        rr_dist = 0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                rr_dist = (i >= ptr_i) ? (i - ptr_i) : (i + N - ptr_i);
                if (rr_dist < rr_best) begin
                    rr_best = rr_dist;
                    rr_w    = i;
                end
            end
        end
    end

    // The owner's request is visible through the one-hot grant, so no index decode is needed.
    assign hold_keep = hold & gnt_valid_q & (|(req & gnt_q));

    always_comb begin
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        ptr_d       = ptr_q;
        win         = mode ? rr_w : fix_w;
        if (hold_keep) begin
            gnt_d = gnt_q;
        end else if (req == '0) begin
            gnt_d       = '0;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                gnt_d[i] = (i == win);
            end
            gnt_idx_d   = IDX_W'(win);
            gnt_valid_d = 1'b1;
            if (mode) begin
                ptr_d = (rr_w == N - 1) ? '0 : IDX_W'(rr_w + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule
